// File: rtl/polar_pkg.sv
// Shared constants for the polar-to-cartesian scheduler: angle limits, sine table, FSM states.
package polar_pkg;

    localparam int unsigned ANG_MAX   = 12;
    localparam int unsigned COEF_FRAC = 8;
    localparam int unsigned COEF_W    = 9;

    // sin(15j deg) * 256, j = 0..6; S6 needs the 9th bit
    localparam logic [COEF_W-1:0] S0 = 9'd0;
    localparam logic [COEF_W-1:0] S1 = 9'd66;
    localparam logic [COEF_W-1:0] S2 = 9'd128;
    localparam logic [COEF_W-1:0] S3 = 9'd181;
    localparam logic [COEF_W-1:0] S4 = 9'd222;
    localparam logic [COEF_W-1:0] S5 = 9'd247;
    localparam logic [COEF_W-1:0] S6 = 9'd256;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMulY = 2'd1,
        StMulX = 2'd2
    } state_t;

endpackage

// File: rtl/sin_coef_rom.sv
// Combinational sine coefficient lookup: 3-bit index (0..6) to 9-bit Q8 coefficient.
module sin_coef_rom
    import polar_pkg::*;
(
    input  logic [2:0]        idx,
    output logic [COEF_W-1:0] coef
);

    always_comb begin
        coef = S0;
        unique case (idx)
            3'd0:    coef = S0;
            3'd1:    coef = S1;
            3'd2:    coef = S2;
            3'd3:    coef = S3;
            3'd4:    coef = S4;
            3'd5:    coef = S5;
            3'd6:    coef = S6;
            default: coef = S0;
        endcase
    end

endmodule

// File: rtl/polar_convert_sched.sv
// Round-robin scheduler sharing one constant-coefficient multiplier between two polar requesters.
// Define POLAR_ROUND_EN to round products half-up instead of truncating.
module polar_convert_sched #(
    parameter int unsigned R_WIDTH   = 8,
    parameter int unsigned COEF_FRAC = polar_pkg::COEF_FRAC,
    parameter int unsigned ANG_MAX   = polar_pkg::ANG_MAX
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_a,
    input  logic [R_WIDTH-1:0] r_a,
    input  logic [3:0]         ang_a,
    output logic               ack_a,
    input  logic               req_b,
    input  logic [R_WIDTH-1:0] r_b,
    input  logic [3:0]         ang_b,
    output logic               ack_b,
    output logic               busy,
    output logic               out_valid,
    output logic               out_src,
    output logic [R_WIDTH:0]   out_x,
    output logic [R_WIDTH-1:0] out_y
);

    import polar_pkg::*;

    localparam int unsigned PW      = R_WIDTH + COEF_W;
    localparam logic [3:0]  ANG_LIM = 4'(ANG_MAX);
`ifdef POLAR_ROUND_EN
    localparam logic [PW:0] RND = (PW+1)'(1) << (COEF_FRAC - 1);
`else
    localparam logic [PW:0] RND = '0;
`endif

    state_t state, state_next;

    logic               last_grant;  // 0 = A, 1 = B
    logic [R_WIDTH-1:0] r_reg;
    logic [3:0]         ang_reg;
    logic               src_reg;
    logic [R_WIDTH-1:0] y_reg;

    logic               grant_any, grant_b;
    logic [3:0]         ang_sel, ang_clamped;
    logic [3:0]         y_idx, x_idx;
    logic [2:0]         coef_idx;
    logic [COEF_W-1:0]  coef;
    logic [PW-1:0]      prod;
    logic [PW:0]        sum;
    logic [R_WIDTH-1:0] mag;
    logic [R_WIDTH:0]   x_val;
    logic               unused_bits;

    // On a tie, the requester not granted last time wins
    assign grant_any   = req_a | req_b;
    assign grant_b     = req_b & (~req_a | ~last_grant);
    assign ang_sel     = grant_b ? ang_b : ang_a;
    assign ang_clamped = (ang_sel > ANG_LIM) ? ANG_LIM : ang_sel;

    assign y_idx    = (ang_reg <= 4'd6) ? ang_reg : 4'd12 - ang_reg;
    assign x_idx    = (ang_reg <= 4'd6) ? 4'd6 - ang_reg : ang_reg - 4'd6;
    assign coef_idx = (state == StMulX) ? x_idx[2:0] : y_idx[2:0];

    sin_coef_rom u_rom (
        .idx  (coef_idx),
        .coef (coef)
    );

    assign prod = {{(PW-R_WIDTH){1'b0}}, r_reg} * {{(PW-COEF_W){1'b0}}, coef};
    assign sum  = {1'b0, prod} + RND;
    // Saturate anything that would spill above the magnitude width
    assign mag  = (|sum[PW:COEF_FRAC+R_WIDTH]) ? '1 : sum[COEF_FRAC+R_WIDTH-1:COEF_FRAC];
    assign x_val = (ang_reg > 4'd6) ? -{1'b0, mag} : {1'b0, mag};

    assign unused_bits = ^{sum[COEF_FRAC-1:0], y_idx[3], x_idx[3]};

    assign busy = (state != StIdle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle:  if (grant_any) state_next = StMulY;
            StMulY:  state_next = StMulX;
            StMulX:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            r_reg      <= '0;
            ang_reg    <= '0;
            src_reg    <= 1'b0;
            y_reg      <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            out_valid  <= 1'b0;
            out_src    <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
        end else begin
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            out_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_any) begin
                        r_reg      <= grant_b ? r_b : r_a;
                        ang_reg    <= ang_clamped;
                        src_reg    <= grant_b;
                        ack_a      <= ~grant_b;
                        ack_b      <= grant_b;
                        last_grant <= grant_b;
                    end
                end
                StMulY: y_reg <= mag;
                StMulX: begin
                    out_x     <= x_val;
                    out_y     <= y_reg;
                    out_src   <= src_reg;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_convert_sched.sv
// Scoreboard bench for polar_convert_sched: directed requests queue expected results, a monitor checks.
module tb_polar_convert_sched;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req_a, req_b;
    logic [7:0] r_a, r_b;
    logic [3:0] ang_a, ang_b;
    logic       ack_a, ack_b, busy, out_valid, out_src;
    logic [8:0] out_x;
    logic [7:0] out_y;

    always #5 clock = ~clock;

    polar_convert_sched dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_a     (req_a),
        .r_a       (r_a),
        .ang_a     (ang_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .r_b       (r_b),
        .ang_b     (ang_b),
        .ack_b     (ack_b),
        .busy      (busy),
        .out_valid (out_valid),
        .out_src   (out_src),
        .out_x     (out_x),
        .out_y     (out_y)
    );

`ifdef POLAR_ROUND_EN
    localparam logic [7:0] Y_R255_K1 = 8'd66;
`else
    localparam logic [7:0] Y_R255_K1 = 8'd65;
`endif

    typedef struct {
        logic       src;
        logic [8:0] x;
        logic [7:0] y;
        int         gap;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   last_ack = -100;
    int   last_valid = -100;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_result(input bit src, input logic [8:0] x, input logic [7:0] y,
                                 input int gap);
        exp_t e;
        e.src = src;
        e.x   = x;
        e.y   = y;
        e.gap = gap;
        expq.push_back(e);
    endtask

    // Monitor: sample on falling edge, away from the active edge
    always @(negedge clock) begin
        exp_t e;
        cycle++;
        if (reset_n) begin
            if (ack_a || ack_b) begin
                last_ack = cycle;
                check("busy_at_ack", int'(busy), 1);
            end
            if (out_valid) begin
                check("ack_to_valid", cycle - last_ack, 2);
                check("busy_at_valid", int'(busy), 0);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got src=%0d x=%0d y=%0d, expected none",
                             out_src, out_x, out_y);
                end else begin
                    e = expq.pop_front();
                    check("out_src", int'(out_src), int'(e.src));
                    check("out_x", int'(out_x), int'(e.x));
                    check("out_y", int'(out_y), int'(e.y));
                    if (e.gap != 0) check("valid_gap", cycle - last_valid, e.gap);
                end
                last_valid = cycle;
            end
        end
    end

    task automatic issue(input bit src, input logic [7:0] r, input logic [3:0] ang,
                         input logic [8:0] x, input logic [7:0] y);
        int n;
        expect_result(src, x, y, 0);
        if (src) begin
            req_b = 1'b1; r_b = r; ang_b = ang;
        end else begin
            req_a = 1'b1; r_a = r; ang_a = ang;
        end
        for (n = 0; n < 20; n++) begin
            @(negedge clock);
            if (src ? ack_b : ack_a) break;
        end
        check("ack_seen", int'(n < 20), 1);
        // Scramble operands after ack; the conversion in flight must ignore them
        if (src) begin
            req_b = 1'b0; r_b = 8'($urandom); ang_b = 4'($urandom);
        end else begin
            req_a = 1'b0; r_a = 8'($urandom); ang_a = 4'($urandom);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && expq.size() != 0; n++) @(negedge clock);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acks;
        bit ok;
        reset_n = 1'b1;
        req_a = 1'b0; r_a = '0; ang_a = '0;
        req_b = 1'b0; r_b = '0; ang_b = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_outputs", int'({ack_a, ack_b, busy, out_valid, out_src, out_x, out_y}), 0);
        reset_n = 1'b1;
        @(negedge clock);

        issue(1'b0, 8'd200, 4'd2,  9'd173,     8'd100);
        issue(1'b1, 8'd200, 4'd9,  -9'sd141,   8'd141);
        issue(1'b1, 8'd255, 4'd12, -9'sd255,   8'd0);
        issue(1'b0, 8'd255, 4'd6,  9'd0,       8'd255);
        issue(1'b0, 8'd10,  4'd15, -9'sd10,    8'd0);
        issue(1'b0, 8'd255, 4'd1,  9'd246,     Y_R255_K1);
        issue(1'b1, 8'd50,  4'd4,  9'd25,      8'd43);
        drain();

        // Both held: last grant was B, so order is A, B, A, B
        expect_result(1'b0, 9'd100, 8'd0,  0);
        expect_result(1'b1, 9'd25,  8'd43, 3);
        expect_result(1'b0, 9'd100, 8'd0,  3);
        expect_result(1'b1, 9'd25,  8'd43, 3);
        req_a = 1'b1; r_a = 8'd100; ang_a = 4'd0;
        req_b = 1'b1; r_b = 8'd50;  ang_b = 4'd4;
        acks = 0;
        for (int n = 0; n < 40 && acks < 4; n++) begin
            @(negedge clock);
            if (ack_a || ack_b) acks++;
        end
        req_a = 1'b0; req_b = 1'b0;
        check("fair_acks", acks, 4);
        drain();

        // Abort a conversion by reset during MUL_X
        req_a = 1'b1; r_a = 8'd7; ang_a = 4'd0;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (ack_a) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_ack", int'(ok), 1);
        r_a = 8'd20; ang_a = 4'd7;
        req_b = 1'b1; r_b = 8'd128; ang_b = 4'd8;
        @(negedge clock);
        check("abort_in_mulx_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort_outputs_zero",
              int'({ack_a, ack_b, busy, out_valid, out_src, out_x, out_y}), 0);
        repeat (3) begin
            @(negedge clock);
            check("abort_no_valid", int'(out_valid), 0);
        end
        // After release A wins the tie again since last_grant resets to B
        expect_result(1'b0, -9'sd5,  8'd19,  0);
        expect_result(1'b1, -9'sd64, 8'd111, 3);
        reset_n = 1'b1;
        acks = 0;
        for (int n = 0; n < 30 && acks < 2; n++) begin
            @(negedge clock);
            if (ack_a) begin
                req_a = 1'b0;
                acks++;
            end
            if (ack_b) begin
                req_b = 1'b0;
                acks++;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        check("post_reset_acks", acks, 2);
        drain();

        check("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/polar_convert_sched.md
Name: polar_convert_sched

Overview:
Arbitrates and sequences one shared constant-coefficient multiplier that converts polar (r, angle) to cartesian (x, y).
- Angle is an index k in 0..12, meaning theta = 15k degrees.
- Two requesters share the unit: A is the ultrasound sweep and B is the rover locator.
- Round-robin grant, one multiply per cycle, results tagged with the source requester.
- Sits between the sensor-processing logic and the display/map logic.

Parameters:
R_WIDTH, 8, magnitude width of r (unsigned).
COEF_FRAC, 8, fractional bits of the sin coefficients (scale 256).
ANG_MAX, 12, largest legal angle index.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_a  in  1  requester A request; held high until ack_a
r_a  in  8  requester A magnitude
ang_a  in  4  requester A angle index
ack_a  out  1  one-cycle pulse; A's operands are latched
req_b  in  1  requester B request; held high until ack_b
r_b  in  8  requester B magnitude
ang_b  in  4  requester B angle index
ack_b  out  1  one-cycle pulse; B's operands are latched
busy  out  1  high in MUL_Y and MUL_X
out_valid  out  1  one-cycle pulse; result is ready
out_src  out  1  0 = A, 1 = B
out_x  out  9  signed r*cos(theta), range -255..255
out_y  out  8  unsigned r*sin(theta), range 0..255

Behaviour:
- Clock and reset:
  - Single clock, named clock.
  - Reset is asynchronous and active-low, named reset_n.
  - While reset_n = 0: all outputs are 0, state = IDLE, last_grant = B (so A wins the first tie).
  - An assertion of reset_n mid-operation aborts the conversion. No ack or out_valid is produced afterwards for the aborted request.
- Coefficient table S[j], j = 0..6, is sin(15j) * 256: 0, 66, 128, 181, 222, 247, 256. S[6] = 256 needs 9 bits.
- Angle mapping:
  - y = (r * S[min(k, 12-k)]) >> 8.
  - For k <= 6: x = +(r * S[6-k]) >> 8.
  - For k > 6: x = -((r * S[k-6]) >> 8). Negate after the shift.
  - Any ang > 12 is clamped to 12.
- Arithmetic: product width is 8 x 9 = 17 bits unsigned, then shifted right by 8. out_y is the low 8 bits; this never overflows because r*256 >> 8 = r. out_x is sign-extended to 9 bits.
- FSM IDLE -> MUL_Y -> MUL_X -> IDLE:
  - In IDLE, at an edge where req_a or req_b is high:
    - Select the requester; if both are high, take the one not in last_grant.
    - Latch r, the clamped ang and src.
    - Pulse the matching ack for exactly the next cycle.
    - Update last_grant and go to MUL_Y.
  - In MUL_Y: register y_reg, go to MUL_X.
  - In MUL_X: register out_x; copy y_reg to out_y; set out_src; pulse out_valid; go to IDLE.
  - In IDLE with no request: stay in IDLE.
- Timing:
  - out_valid is high in the 2nd cycle after the ack cycle.
  - A new grant is possible at the edge closing the out_valid cycle.
  - Throughput is one conversion per 3 cycles.
- Output hold: out_x, out_y and out_src hold their values until the next out_valid.
- Request sampling: req is only sampled in IDLE. Operand changes after ack have no effect on the conversion in flight.
- Fairness: with both requests held continuously, grants alternate A, B, A, B...
- There is one shared multiplier instance, muxed by state between sin and cos coefficients.

Optional Feature:
- Macro POLAR_ROUND_EN.
- Defined: both products become (r*c + 128) >> 8, round-half-up. The 18-bit intermediate is still clamped so magnitudes stay at or below 255.
- Undefined: truncate, as defined above.

Decomposition:
- Package polar_pkg holds:
  - ANG_MAX
  - COEF_FRAC
  - the S[0..6] coefficient constants
  - FSM state encodings for IDLE, MUL_Y and MUL_X
- Sub-module sin_coef_rom: combinational 3-bit index to 9-bit coefficient.
- Arbiter, FSM and shared multiplier stay in the top module.

Test Plan:
- Reset then A: r=200, k=2 -> ack_a 1 cycle; 2 cycles later out_valid, out_src=0, out_y=100, out_x=173.
- B alone: r=200, k=9 -> out_y=141, out_x=-141 (9'h173); r=255, k=12 -> out_y=0, out_x=-255.
- Boundaries: r=255, k=6 -> out_y=255, out_x=0. ang=15 with r=10 -> treated as 12: out_y=0, out_x=-10.
- Both requests held for 4 conversions -> grant order A, B, A, B. Each ack is a single cycle; out_valid is spaced 3 cycles apart.
- reset_n dropped during MUL_X -> out_valid never pulses; outputs are 0. After release, a pending req_a is granted normally.
- POLAR_ROUND_EN: r=255, k=1 -> out_y=66 with the macro defined, 65 without; out_x=246 in both builds.
